// File: rtl/toggle_ctrl_pkg.sv
// Shared types and phase helpers for the toggle-path sequencer.
package toggle_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] PHASE_A = 2'b01;
    localparam logic [1:0] PHASE_B = 2'b10;

    // Any illegal encoding recovers to PHASE_A on the next flip.
    function automatic logic [1:0] next_phase(input logic [1:0] phase);
        return (phase == PHASE_A) ? PHASE_B : PHASE_A;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter that holds at zero; load takes priority over count.
module dwell_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/toggle_phase_controller.sv
// Start/stop sequencer for the one-hot toggle path with per-phase dwell.
// state | meaning
// IDLE  | waiting for start; toggle_out holds its last phase
// RUN   | dwelling / flipping until num_toggles changes or stop
module toggle_phase_controller
    import toggle_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] dwell_a_i,
    input  logic [CNT_W-1:0] dwell_b_i,
    input  logic [CNT_W-1:0] num_toggles_i,
    output logic [1:0]       toggle_out_o,
    output logic             latch_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    state_e           state_q, state_d;
    logic [1:0]       toggle_q, toggle_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] dwell_a_q, dwell_a_d;
    logic [CNT_W-1:0] dwell_b_q, dwell_b_d;
    logic [CNT_W-1:0] num_q, num_d;

    logic             dwell_zero;
    logic             dwell_load;
    logic             dwell_en;
    logic [CNT_W-1:0] dwell_load_val;

    logic             accept;
    logic             flip_due;
    logic             final_flip;
    logic             abort;
    logic             do_flip;
    logic [1:0]       phase_nxt;

    // Counter is loaded with dwell-1; a programmed 0 behaves like 1.
    function automatic logic [CNT_W-1:0] dwell_ld(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    always_comb begin
        accept     = (state_q == IDLE) && start_i;
        flip_due   = (state_q == RUN) && dwell_zero;
        final_flip = flip_due && ((tcnt_q + CNT_W'(1)) == num_q);
        abort      = (state_q == RUN) && stop_i && !final_flip;
        do_flip    = flip_due && !abort;
        phase_nxt  = next_phase(toggle_q);
    end

    dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell_counter (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (dwell_load),
        .load_val_i (dwell_load_val),
        .en_i       (dwell_en),
        .zero_o     (dwell_zero)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            toggle_q  <= PHASE_A;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            tcnt_q    <= '0;
            dwell_a_q <= '0;
            dwell_b_q <= '0;
            num_q     <= '0;
        end else begin
            state_q   <= state_d;
            toggle_q  <= toggle_d;
            latch_q   <= latch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            tcnt_q    <= tcnt_d;
            dwell_a_q <= dwell_a_d;
            dwell_b_q <= dwell_b_d;
            num_q     <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i && (num_toggles_i != '0)) state_d = RUN;
            RUN:  if (final_flip || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        toggle_d       = toggle_q;
        latch_d        = do_flip;
        busy_d         = (state_d == RUN);
        done_d         = final_flip || (accept && (num_toggles_i == '0));
        aborted_d      = abort;
        tcnt_d         = tcnt_q;
        dwell_a_d      = dwell_a_q;
        dwell_b_d      = dwell_b_q;
        num_d          = num_q;
        dwell_load     = 1'b0;
        dwell_load_val = '0;
        dwell_en       = (state_q == RUN) && !dwell_zero;

        if (accept) begin
            dwell_a_d      = dwell_a_i;
            dwell_b_d      = dwell_b_i;
            num_d          = num_toggles_i;
            tcnt_d         = '0;
            dwell_load     = 1'b1;
            dwell_load_val = dwell_ld((toggle_q == PHASE_A) ? dwell_a_i : dwell_b_i);
        end else if (do_flip) begin
            toggle_d = phase_nxt;
            tcnt_d   = tcnt_q + CNT_W'(1);
            if (!final_flip) begin
                dwell_load     = 1'b1;
                dwell_load_val = dwell_ld((phase_nxt == PHASE_A) ? dwell_a_q : dwell_b_q);
            end
        end
    end

    assign toggle_out_o = toggle_q;
    assign latch_en_o   = latch_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign aborted_o    = aborted_q;

endmodule

// File: tb/tb_toggle_phase_controller.sv
// Bench for toggle_phase_controller: directed scenarios plus random traffic vs. a flip-schedule model.
module tb_toggle_phase_controller;

    logic       clk_i = 1'b0;
    logic       rst_n_i, start_i, stop_i;
    logic [7:0] dwell_a_i, dwell_b_i, num_toggles_i;
    logic [1:0] toggle_out_o;
    logic       latch_en_o, busy_o, done_o, aborted_o;

    always #5 clk_i = ~clk_i;

    toggle_phase_controller #(.CNT_W(8)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .stop_i        (stop_i),
        .dwell_a_i     (dwell_a_i),
        .dwell_b_i     (dwell_b_i),
        .num_toggles_i (num_toggles_i),
        .toggle_out_o  (toggle_out_o),
        .latch_en_o    (latch_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .aborted_o     (aborted_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // Model: on start, the absolute edge numbers of every flip are precomputed.
    logic [1:0] m_phase = 2'b01;
    logic       m_run = 1'b0, m_latch = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_abort = 1'b0;
    int         m_sched[$];

    int lat_cnt, busy_cnt, done_cnt, abort_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    function automatic int eff_dwell(input logic [7:0] d);
        return (d == 8'd0) ? 1 : int'(d);
    endfunction

    task automatic model_edge();
        int t;
        logic [1:0] p;
        edge_n++;
        m_latch = 1'b0;
        m_done  = 1'b0;
        m_abort = 1'b0;
        if (!rst_n_i) begin
            m_phase = 2'b01;
            m_run   = 1'b0;
            m_sched.delete();
        end else if (m_run) begin
            if (m_sched[0] == edge_n && (m_sched.size() == 1 || !stop_i)) begin
                m_phase = (m_phase == 2'b01) ? 2'b10 : 2'b01;
                m_latch = 1'b1;
                void'(m_sched.pop_front());
                if (m_sched.size() == 0) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end else if (stop_i) begin
                m_run   = 1'b0;
                m_abort = 1'b1;
                m_sched.delete();
            end
        end else if (start_i) begin
            if (num_toggles_i == 8'd0) begin
                m_done = 1'b1;
            end else begin
                t = edge_n;
                p = m_phase;
                for (int k = 0; k < int'(num_toggles_i); k++) begin
                    t += eff_dwell((p == 2'b01) ? dwell_a_i : dwell_b_i);
                    m_sched.push_back(t);
                    p = (p == 2'b01) ? 2'b10 : 2'b01;
                end
                m_run = 1'b1;
            end
        end
        m_busy = m_run;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check_eq("toggle_out", 32'(toggle_out_o), 32'(m_phase));
        check_eq("latch_en",   32'(latch_en_o),   32'(m_latch));
        check_eq("busy",       32'(busy_o),       32'(m_busy));
        check_eq("done",       32'(done_o),       32'(m_done));
        check_eq("aborted",    32'(aborted_o),    32'(m_abort));
        lat_cnt   += int'(latch_en_o);
        busy_cnt  += int'(busy_o);
        done_cnt  += int'(done_o);
        abort_cnt += int'(aborted_o);
    endtask

    task automatic clr_counts();
        lat_cnt = 0; busy_cnt = 0; done_cnt = 0; abort_cnt = 0;
    endtask

    task automatic set_run(input logic [7:0] da, input logic [7:0] db, input logic [7:0] nt);
        dwell_a_i = da; dwell_b_i = db; num_toggles_i = nt;
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
        set_run(8'd0, 8'd0, 8'd0);
        clr_counts();
        step(); step();
        rst_n_i = 1'b1;
        step();

        // Basic run 3/2/3 from phase 01: flips at E3, E5, E8.
        set_run(8'd3, 8'd2, 8'd3);
        start_i = 1'b1;
        clr_counts();
        for (int i = 0; i < 9; i++) begin
            step();
            start_i = 1'b0;
        end
        check_eq("t1_latch_pulses", 32'(lat_cnt), 32'd3);
        check_eq("t1_busy_cycles",  32'(busy_cnt), 32'd8);
        check_eq("t1_done_pulses",  32'(done_cnt), 32'd1);
        check_eq("t1_phase",        32'(toggle_out_o), 32'h2);

        // Restart in the done cycle: starts from 10, dwell_b=2.
        set_run(8'd3, 8'd2, 8'd1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step(); step();
        check_eq("cont_phase", 32'(toggle_out_o), 32'h1);
        check_eq("cont_done",  32'(done_o), 32'd1);

        // num_toggles = 0
        step();
        set_run(8'd2, 8'd2, 8'd0);
        start_i = 1'b1;
        clr_counts();
        step();
        start_i = 1'b0;
        check_eq("zero_nt_done", 32'(done_o), 32'd1);
        step(); step();
        check_eq("zero_nt_latch", 32'(lat_cnt), 32'd0);
        check_eq("zero_nt_busy",  32'(busy_cnt), 32'd0);

        // dwell_a = 0 acts like 1
        set_run(8'd0, 8'd1, 8'd2);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Abort at E7 with 5/5/4 from phase 01.
        rst_n_i = 1'b0; step(); rst_n_i = 1'b1; step();
        set_run(8'd5, 8'd5, 8'd4);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check_eq("abort_pulse", 32'(aborted_o), 32'd1);
        check_eq("abort_phase", 32'(toggle_out_o), 32'h2);
        clr_counts();
        for (int i = 0; i < 12; i++) step();
        check_eq("abort_no_latch", 32'(lat_cnt), 32'd0);
        check_eq("abort_no_done",  32'(done_cnt), 32'd0);

        // Stop on the final-flip edge: done wins.
        set_run(8'd2, 8'd2, 8'd1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        check_eq("final_stop_done",  32'(done_o), 32'd1);
        check_eq("final_stop_abort", 32'(aborted_o), 32'd0);

        // start held high through a run
        set_run(8'd2, 8'd3, 8'd2);
        start_i = 1'b1;
        for (int i = 0; i < 10; i++) step();
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // start + stop together in IDLE
        set_run(8'd1, 8'd1, 8'd1);
        start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        check_eq("start_stop_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) step();

        // Reset mid-dwell, then a fresh run behaves as after reset.
        set_run(8'd6, 8'd6, 8'd2);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        check_eq("rst_phase", 32'(toggle_out_o), 32'h1);
        check_eq("rst_busy",  32'(busy_o), 32'd0);
        set_run(8'd3, 8'd2, 8'd3);
        start_i = 1'b1;
        clr_counts();
        for (int i = 0; i < 9; i++) begin
            step();
            start_i = 1'b0;
        end
        check_eq("rst_rerun_latch", 32'(lat_cnt), 32'd3);
        check_eq("rst_rerun_busy",  32'(busy_cnt), 32'd8);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n_i       = ($urandom_range(0, 199) != 0);
            start_i       = ($urandom_range(0, 7) == 0);
            stop_i        = ($urandom_range(0, 15) == 0);
            dwell_a_i     = 8'($urandom_range(0, 6));
            dwell_b_i     = 8'($urandom_range(0, 6));
            num_toggles_i = 8'($urandom_range(0, 5));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/toggle_phase_controller.md
# toggle_phase_controller

Synchronous sequencer for the 2-bit one-hot toggle path (phases 2'b01 and 2'b10). It owns the toggle state register and holds each phase for a programmable dwell time. It issues a one-cycle latch-enable pulse on every phase change and stops after a programmed number of changes. It sits upstream of the level-sensitive toggle latch and replaces free-running enable generation with a start/stop-controlled run.

## Interface
Parameters:
- CNT_W, 8, width of the dwell and toggle-count fields and internal counters

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  run request; sampled only in IDLE
- stop  in  1  abort request; sampled only while busy
- dwell_a  in  CNT_W  cycles to hold phase 2'b01; sampled with start
- dwell_b  in  CNT_W  cycles to hold phase 2'b10; sampled with start
- num_toggles  in  CNT_W  phase changes per run; sampled with start
- toggle_out  out  2  current phase, one-hot
- latch_en  out  1  one-cycle pulse, high in the first cycle toggle_out shows a new phase
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, run completed normally
- aborted  out  1  one-cycle pulse, run ended by stop

## Operation
- Reset values: toggle_out=2'b01, latch_en=0, busy=0, done=0, aborted=0, state=IDLE, counters=0.
- States: IDLE, RUN.
- IDLE + start=1:
  - Capture dwell_a, dwell_b and num_toggles.
  - If num_toggles=0: pulse done on the next cycle, stay in IDLE, no phase change.
  - Otherwise: go to RUN and load the dwell counter with (dwell of the current phase)−1.
- Current phase selects the dwell: toggle_out=2'b01 uses dwell_a; toggle_out=2'b10 uses dwell_b.
- A dwell value of 0 is treated as 1.
- The starting phase is whatever toggle_out holds. It is not reset between runs.
- RUN, each cycle:
  - If the dwell counter ≠ 0: decrement it.
  - If the dwell counter = 0: flip toggle_out (01↔10), pulse latch_en, and increment the toggle count.
    - If the count now equals num_toggles: pulse done, drop busy, return to IDLE.
    - Otherwise: reload the dwell counter from the new phase's dwell−1.
- Illegal phase recovery: if toggle_out is ever 2'b00 or 2'b11, the next flip produces 2'b01.
- stop=1 in RUN:
  - At that edge: return to IDLE, drop busy, pulse aborted.
  - No flip and no latch_en.
  - toggle_out keeps its current phase.
- Simultaneous events:
  - A final flip and stop on the same edge: the flip and done win; stop is ignored.
  - A non-final flip and stop on the same edge: stop wins; no flip.
  - start and stop together in IDLE: start is accepted.
  - start while busy: ignored.
- Reset mid-run: all outputs return to reset values at that edge. A latch_en pulse in flight is dropped.
- Counter arithmetic: unsigned CNT_W bits, no wrap. The toggle counter never exceeds num_toggles.

## Timing
- E0 is the edge that samples start. busy=1 from E0 through the edge of the final flip.
- The first flip occurs at edge E(d0), where d0 is the effective dwell of the starting phase. latch_en is high for the cycle after that edge.
- Successive flips are spaced by the effective dwell of the phase being left.
- done coincides with the final latch_en cycle. busy is 0 in that same cycle.
- busy duration = sum of effective dwells over the run, in cycles.
- A new start is accepted in the cycle done is high (the state is already IDLE).
- aborted and done are mutually exclusive.

## Structure
- Package toggle_ctrl_pkg holds:
  - the state enum (IDLE, RUN)
  - localparams PHASE_A=2'b01 and PHASE_B=2'b10
  - a function next_phase() that maps 01→10 and everything else→01
- Sub-module dwell_counter: a loadable CNT_W down-counter with load, en and zero outputs. It is instantiated once.
- Toggle count, FSM and output registers live in the top module.
- All outputs are registered.

## Test plan
- Reset, then start with dwell_a=3, dwell_b=2, num_toggles=3 and toggle_out=01:
  - flips at E3 (→10), E5 (→01), E8 (→10)
  - latch_en high exactly 3 cycles
  - done with the E8 flip
  - busy for 8 cycles
- Continuity: rerun with num_toggles=1 immediately after done. The run starts from 10, uses dwell_b, and the first flip returns toggle_out to 01.
- Zero cases:
  - num_toggles=0 → done pulse one cycle after start, no latch_en, busy stays 0
  - dwell_a=0 → behaves as dwell_a=1
- Abort: dwell_a=dwell_b=5, num_toggles=4, stop asserted at E7 → aborted pulse, toggle_out stays 10, no further latch_en, done never asserted.
- Collisions:
  - stop on the final-flip edge → done only
  - start held high during RUN → no restart
  - start+stop in IDLE → run begins
- rst_n low for one cycle mid-dwell → toggle_out=01 and all flags 0 on the next cycle; a subsequent start behaves as after a fresh reset.
